nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_pkg.sv | 21 ++
 rtl/nsa_add4.sv | 24 ++
 rtl/nibble_serial_adder.sv | 126 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, nibble width
// and the nibble counter width helper.
package nibble_serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } nsa_state_e;

  // A single-nibble build still needs a 1-bit counter to stay a legal vector.
  function automatic int unsigned cnt_width(input int unsigned nibbles);
    if (nibbles <= 1) begin
      return 1;
    end
    return $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nsa_add4.sv
// Combinational 4-bit ripple-carry stage shared by every nibble of the
// serial adder.
module nsa_add4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that walks the operands one nibble per clock through a single
// 4-bit stage, linking nibbles with a registered carry.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int unsigned W  = NIBBLE_W * NIBBLES;
  localparam int unsigned CW = cnt_width(NIBBLES);

  localparam logic [CW-1:0] LastCnt = CW'(NIBBLES - 1);
  localparam logic [W-1:0]  NibMask = W'(4'hF);

  nsa_state_e state_q;

  logic [CW-1:0] cnt_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry_q;

  logic [CW+1:0]       nib_idx;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic                last_nib;
  logic                ovf_d;
  logic [W-1:0]        sum_d;

  // Bit offset of the active nibble; shifts keep the N=1 build free of
  // out-of-range part selects.
  assign nib_idx  = {cnt_q, 2'b00};
  assign nib_a    = NIBBLE_W'(a_q >> nib_idx);
  assign nib_b    = NIBBLE_W'(b_q >> nib_idx);
  assign last_nib = (cnt_q == LastCnt);

  nsa_add4 u_add4 (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_comb begin
    sum_d = (out_sum & ~(NibMask << nib_idx)) | (W'(nib_sum) << nib_idx);
    // Signed overflow only needs the operand MSBs and the final sum MSB.
    ovf_d = (a_q[W-1] == b_q[W-1]) && (nib_sum[NIBBLE_W-1] != a_q[W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            b_q      <= in_b;
            carry_q  <= in_cin;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_q  <= StAdd;
          end
        end

        StAdd: begin
          out_sum <= sum_d;
          carry_q <= nib_cout;
          if (last_nib) begin
            cnt_q     <= '0;
            out_cout  <= nib_cout;
            out_ovf   <= ovf_d;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for the nibble-serial adder: a 4-nibble and a 1-nibble
// instance sharing one clock and reset.
module tb_nibble_serial_adder;

  logic clk;
  logic rst_n;

  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_ovf, busy;
  logic [15:0] in_a, in_b, out_sum;

  logic       in_valid1, in_ready1, in_cin1, out_valid1, out_ready1, out_cout1, out_ovf1, busy1;
  logic [3:0] in_a1, in_b1, out_sum1;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_a      (in_a1),
    .in_b      (in_b1),
    .in_cin    (in_cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_sum   (out_sum1),
    .out_cout  (out_cout1),
    .out_ovf   (out_ovf1),
    .busy      (busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Presents one operand set to the 4-nibble DUT; returns 1 ns after the acceptance edge.
  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from acceptance (the acceptance edge is edge 1) until out_valid.
  task automatic wait_valid(output int edges);
    edges = 1;
    while (out_valid !== 1'b1 && edges < 30) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_cin1 = 1'b0; out_ready1 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/valid/busy=%b required 100", {in_ready, out_valid, busy});
    end
    n_checks++;
    if ({out_cout, out_ovf, out_sum} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_data: cout/ovf/sum=%h required 0", {out_cout, out_ovf, out_sum});
    end
    n_checks++;
    if ({in_ready1, out_valid1, busy1, out_sum1} !== 7'b100_0000) begin
      n_fail++;
      $display("FAIL reset_n1: got %b required 1000000", {in_ready1, out_valid1, busy1, out_sum1});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_latency();
    int edges;
    accept(16'h00FF, 16'h0001, 1'b0);
    n_checks++;
    if ({busy, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL add_flags: busy/in_ready=%b required 10", {busy, in_ready});
    end
    wait_valid(edges);
    n_checks++;
    if (edges !== 5) begin
      n_fail++;
      $display("FAIL latency: out_valid after %0d edges, required 5", edges);
    end
    n_checks++;
    if ({out_cout, out_ovf, out_sum} !== {2'b00, 16'h0100}) begin
      n_fail++;
      $display("FAIL sum_00ff: got cout=%b ovf=%b sum=%h required 0 0 0100", out_cout, out_ovf, out_sum);
    end
    handshake();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL after_hs: valid/ready=%b required 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_ripple();
    int edges;
    accept(16'hFFFF, 16'h0001, 1'b0);
    wait_valid(edges);
    n_checks++;
    if ({out_valid, out_cout, out_ovf, out_sum} !== {3'b110, 16'h0000}) begin
      n_fail++;
      $display("FAIL ripple: got v=%b cout=%b ovf=%b sum=%h required 1 1 0 0000", out_valid, out_cout, out_ovf, out_sum);
    end
    handshake();
  endtask

  task automatic test_overflow();
    int edges;
    accept(16'h7FFF, 16'h0000, 1'b1);
    wait_valid(edges);
    n_checks++;
    if ({out_valid, out_cout, out_ovf, out_sum} !== {3'b101, 16'h8000}) begin
      n_fail++;
      $display("FAIL ovf_pos: got v=%b cout=%b ovf=%b sum=%h required 1 0 1 8000", out_valid, out_cout, out_ovf, out_sum);
    end
    handshake();
    accept(16'h8000, 16'h8000, 1'b0);
    wait_valid(edges);
    n_checks++;
    if ({out_valid, out_cout, out_ovf, out_sum} !== {3'b111, 16'h0000}) begin
      n_fail++;
      $display("FAIL ovf_neg: got v=%b cout=%b ovf=%b sum=%h required 1 1 1 0000", out_valid, out_cout, out_ovf, out_sum);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int edges;
    int bad = 0;
    accept(16'h1234, 16'h4321, 1'b0);
    wait_valid(edges);
    in_a = 16'hAAAA; in_b = 16'h5555; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({out_valid, in_ready, out_cout, out_ovf, out_sum} !== {4'b1000, 16'h5555}) begin
        n_fail++;
        bad++;
        $display("FAIL hold_%0d: v=%b rdy=%b cout=%b ovf=%b sum=%h required 1 0 0 0 5555",
                 i, out_valid, in_ready, out_cout, out_ovf, out_sum);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    handshake();
    n_checks++;
    if ({out_valid, in_ready, busy, out_sum} !== {3'b010, 16'h5555}) begin
      n_fail++;
      $display("FAIL bp_release: v=%b rdy=%b busy=%b sum=%h required 0 1 0 5555", out_valid, in_ready, busy, out_sum);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_no_new_op: valid/busy=%b required 00", {out_valid, busy});
    end
  endtask

  task automatic test_reset_mid_add();
    int edges;
    accept(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, out_cout, out_ovf, out_sum} !== {3'b100, 18'h0}) begin
      n_fail++;
      $display("FAIL async_clear: rdy=%b v=%b busy=%b cout=%b ovf=%b sum=%h required 1 0 0 0 0 0000",
               in_ready, out_valid, busy, out_cout, out_ovf, out_sum);
    end
    in_a = 16'h0F0F; in_b = 16'h0F0F; in_valid = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL valid_in_reset: busy/v/rdy=%b required 001", {busy, out_valid, in_ready});
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if ({out_valid, busy, out_sum} !== {2'b00, 16'h0000}) begin
      n_fail++;
      $display("FAIL no_stale_result: v=%b busy=%b sum=%h required 0 0 0000", out_valid, busy, out_sum);
    end
    accept(16'h1234, 16'h1111, 1'b0);
    wait_valid(edges);
    n_checks++;
    if ({out_valid, out_cout, out_ovf, out_sum} !== {3'b100, 16'h2345}) begin
      n_fail++;
      $display("FAIL post_reset_op: v=%b cout=%b ovf=%b sum=%h required 1 0 0 2345", out_valid, out_cout, out_ovf, out_sum);
    end
    handshake();
  endtask

  task automatic test_single_nibble();
    int edges;
    in_a1 = 4'hF; in_b1 = 4'h1; in_cin1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    edges = 1;
    while (out_valid1 !== 1'b1 && edges < 30) begin
      @(posedge clk); #1;
      edges++;
    end
    n_checks++;
    if (edges !== 2) begin
      n_fail++;
      $display("FAIL n1_latency: out_valid after %0d edges, required 2", edges);
    end
    n_checks++;
    if ({out_cout1, out_ovf1, out_sum1} !== 6'b10_0001) begin
      n_fail++;
      $display("FAIL n1_sum: cout=%b ovf=%b sum=%h required 1 0 1", out_cout1, out_ovf1, out_sum1);
    end
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    n_checks++;
    if ({out_valid1, in_ready1} !== 2'b01) begin
      n_fail++;
      $display("FAIL n1_hs: valid/ready=%b required 01", {out_valid1, in_ready1});
    end
    in_a1 = 4'h7; in_b1 = 4'h1; in_cin1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid1, out_cout1, out_ovf1, out_sum1} !== 7'b101_1000) begin
      n_fail++;
      $display("FAIL n1_ovf: v=%b cout=%b ovf=%b sum=%h required 1 0 1 8", out_valid1, out_cout1, out_ovf1, out_sum1);
    end
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_ripple();
    test_overflow();
    test_backpressure();
    test_reset_mid_add();
    test_single_nibble();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
